// File: rtl/fetch_unit_if.sv
// Instruction-memory read port shared by the fetch unit and the memory model.
interface fetch_unit_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  mem_req;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch unit for the multicycle datapath: it holds the PC and the IR, and it
// fetches instruction words over a req/ready handshake. It raises stall while
// a fetch is outstanding so the control FSM holds its state.
module fetch_unit #(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           OP_MSB     = 15
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  IRWrite,
  input  logic                  PCWrite,
  input  logic                  PCWriteCond,
  input  logic                  Zero,
  input  logic [1:0]            PCSource,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] ALUOut,
  fetch_unit_if.master          mem,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [3:0]            op,
  output logic                  stall,
  output logic                  fetch_done
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t                state, state_next;
  logic                  req_q, req_next;
  logic [DATA_WIDTH-1:0] fetch_addr, addr_next;
  logic [DATA_WIDTH-1:0] instr_next;
  logic                  stall_next;
  logic                  done_next;
  logic                  pc_load;
  logic [DATA_WIDTH-1:0] pc_src_val;
  logic [DATA_WIDTH-1:0] pc_next;

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = fetch_addr;
  assign op           = instr[OP_MSB -: 4];

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and next values for the registered handshake outputs
  always_comb begin
    state_next = state;
    req_next   = req_q;
    addr_next  = fetch_addr;
    instr_next = instr;
    stall_next = stall;
    done_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (IRWrite) begin
          addr_next  = pc;
          req_next   = 1'b1;
          stall_next = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem.mem_ready) begin
          instr_next = mem.mem_rdata;
          req_next   = 1'b0;
          stall_next = 1'b0;
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // PC next-value select; the loaded value is forced to halfword alignment
  always_comb begin
    pc_load = PCWrite | (PCWriteCond & Zero);
    case (PCSource)
      2'd0:    pc_src_val = ALUResult;
      2'd1:    pc_src_val = ALUOut;
      2'd2:    pc_src_val = {pc[DATA_WIDTH-1:12], instr[11:0]};
      default: pc_src_val = pc;
    endcase
    pc_next = pc_load ? {pc_src_val[DATA_WIDTH-1:1], 1'b0} : pc;
  end

  // Registered outputs. fetch_addr samples the pre-edge pc, so a PC load on
  // the same edge as IRWrite leaves the fetch pointing at the old PC.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc         <= RESET_PC;
      instr      <= '0;
      fetch_addr <= '0;
      req_q      <= 1'b0;
      stall      <= 1'b0;
      fetch_done <= 1'b0;
    end else begin
      pc         <= pc_next;
      instr      <= instr_next;
      fetch_addr <= addr_next;
      req_q      <= req_next;
      stall      <= stall_next;
      fetch_done <= done_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: it applies a cycle-by-cycle vector table,
// then runs hand-written sequences for a long memory wait and for a reset
// asserted while a fetch is outstanding.
module tb_fetch_unit;

  logic        CLK;
  logic        Reset;
  logic        IRWrite;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        Zero;
  logic [1:0]  PCSource;
  logic [15:0] ALUResult;
  logic [15:0] ALUOut;
  logic [15:0] pc;
  logic [15:0] instr;
  logic [3:0]  op;
  logic        stall;
  logic        fetch_done;

  int checks = 0;
  int errors = 0;

  fetch_unit_if #(.DATA_WIDTH(16)) mem_bus ();

  fetch_unit #(
    .DATA_WIDTH(16),
    .RESET_PC  (16'h0000),
    .OP_MSB    (15)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .Zero       (Zero),
    .PCSource   (PCSource),
    .ALUResult  (ALUResult),
    .ALUOut     (ALUOut),
    .mem        (mem_bus.master),
    .pc         (pc),
    .instr      (instr),
    .op         (op),
    .stall      (stall),
    .fetch_done (fetch_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, irw, pcw, pcwc, zero;
    logic [1:0]  psrc;
    logic [15:0] alur, aluo;
    logic        rdy;
    logic [15:0] rdata;
    logic [15:0] e_pc, e_instr, e_addr;
    logic [3:0]  e_op;
    logic        e_req, e_stall, e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, irw, pcw, pcwc, zero, input logic [1:0] psrc,
                     input logic [15:0] alur, aluo, input logic rdy, input logic [15:0] rdata,
                     input logic [15:0] e_pc, e_instr, input logic [3:0] e_op,
                     input logic e_req, input logic [15:0] e_addr,
                     input logic e_stall, e_done);
    vec_t v;
    v.rst = rst; v.irw = irw; v.pcw = pcw; v.pcwc = pcwc; v.zero = zero;
    v.psrc = psrc; v.alur = alur; v.aluo = aluo; v.rdy = rdy; v.rdata = rdata;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_op = e_op; v.e_req = e_req;
    v.e_addr = e_addr; v.e_stall = e_stall; v.e_done = e_done;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic rst, irw, pcw, pcwc, zero, input logic [1:0] psrc,
                       input logic [15:0] alur, aluo, input logic rdy, input logic [15:0] rdata);
    Reset = rst; IRWrite = irw; PCWrite = pcw; PCWriteCond = pcwc; Zero = zero;
    PCSource = psrc; ALUResult = alur; ALUOut = aluo;
    mem_bus.mem_ready = rdy; mem_bus.mem_rdata = rdata;
  endtask

  // One cycle: drive on the falling edge, sample 1 time unit after the rising edge
  task automatic step(input logic rst, irw, pcw, pcwc, zero, input logic [1:0] psrc,
                      input logic [15:0] alur, aluo, input logic rdy, input logic [15:0] rdata);
    @(negedge CLK);
    drive(rst, irw, pcw, pcwc, zero, psrc, alur, aluo, rdy, rdata);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bit seen_done;

    drive(1'b1, 0, 0, 0, 0, 2'd0, 16'h0, 16'h0, 1'b0, 16'h0);

    //   rst irw pcw pcwc z  src alur      aluo      rdy rdata      pc        instr     op    req addr      stl dn
    add(1, 0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 1, 16'h1234, 16'h0000, 16'h0000, 4'h0, 0, 16'h0000, 0, 0);
    add(0, 0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 1, 16'h5555, 16'h0000, 16'h0000, 4'h0, 0, 16'h0000, 0, 0);
    add(0, 1, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1, 16'h0000, 1, 0);
    add(0, 0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1, 16'h0000, 1, 0);
    add(0, 0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1, 16'h0000, 1, 0);
    add(0, 0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 1, 16'h3A05, 16'h0000, 16'h3A05, 4'h3, 0, 16'h0000, 0, 1);
    add(0, 0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h3A05, 4'h3, 0, 16'h0000, 0, 0);
    add(0, 0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 1, 16'hFFFF, 16'h0000, 16'h3A05, 4'h3, 0, 16'h0000, 0, 0);
    add(0, 1, 1, 0, 0, 2'd0, 16'h0002, 16'h0000, 0, 16'h0000, 16'h0002, 16'h3A05, 4'h3, 1, 16'h0000, 1, 0);
    add(0, 0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 1, 16'h1111, 16'h0002, 16'h1111, 4'h1, 0, 16'h0000, 0, 1);
    add(0, 0, 0, 1, 0, 2'd1, 16'h0000, 16'h0040, 0, 16'h0000, 16'h0002, 16'h1111, 4'h1, 0, 16'h0000, 0, 0);
    add(0, 0, 0, 1, 1, 2'd1, 16'h0000, 16'h0040, 0, 16'h0000, 16'h0040, 16'h1111, 4'h1, 0, 16'h0000, 0, 0);
    add(0, 0, 1, 0, 0, 2'd0, 16'h0010, 16'h0000, 0, 16'h0000, 16'h0010, 16'h1111, 4'h1, 0, 16'h0000, 0, 0);
    add(0, 0, 0, 1, 1, 2'd1, 16'h0000, 16'h0041, 0, 16'h0000, 16'h0040, 16'h1111, 4'h1, 0, 16'h0000, 0, 0);
    add(0, 0, 1, 1, 0, 2'd1, 16'h0000, 16'h0080, 0, 16'h0000, 16'h0080, 16'h1111, 4'h1, 0, 16'h0000, 0, 0);
    add(0, 0, 1, 0, 0, 2'd0, 16'h5004, 16'h0000, 0, 16'h0000, 16'h5004, 16'h1111, 4'h1, 0, 16'h0000, 0, 0);
    add(0, 1, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h5004, 16'h1111, 4'h1, 1, 16'h5004, 1, 0);
    add(0, 0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 1, 16'hF123, 16'h5004, 16'hF123, 4'hF, 0, 16'h5004, 0, 1);
    add(0, 0, 1, 0, 0, 2'd2, 16'h0000, 16'h0000, 0, 16'h0000, 16'h5122, 16'hF123, 4'hF, 0, 16'h5004, 0, 0);
    add(0, 0, 1, 0, 0, 2'd3, 16'h0000, 16'h0000, 0, 16'h0000, 16'h5122, 16'hF123, 4'hF, 0, 16'h5004, 0, 0);
    add(0, 0, 1, 0, 0, 2'd0, 16'hFFFF, 16'h0000, 0, 16'h0000, 16'hFFFE, 16'hF123, 4'hF, 0, 16'h5004, 0, 0);
    add(0, 0, 0, 0, 1, 2'd0, 16'h1234, 16'h0000, 0, 16'h0000, 16'hFFFE, 16'hF123, 4'hF, 0, 16'h5004, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].irw, vecs[i].pcw, vecs[i].pcwc, vecs[i].zero, vecs[i].psrc,
           vecs[i].alur, vecs[i].aluo, vecs[i].rdy, vecs[i].rdata);
      check($sformatf("v%0d.pc", i),         pc,                     vecs[i].e_pc);
      check($sformatf("v%0d.instr", i),      instr,                  vecs[i].e_instr);
      check($sformatf("v%0d.op", i),         16'(op),                16'(vecs[i].e_op));
      check($sformatf("v%0d.mem_req", i),    16'(mem_bus.mem_req),   16'(vecs[i].e_req));
      check($sformatf("v%0d.mem_addr", i),   mem_bus.mem_addr,       vecs[i].e_addr);
      check($sformatf("v%0d.stall", i),      16'(stall),             16'(vecs[i].e_stall));
      check($sformatf("v%0d.fetch_done", i), 16'(fetch_done),        16'(vecs[i].e_done));
    end

    // Long memory wait with IRWrite re-asserted during WAIT
    step(0, 0, 1, 0, 0, 2'd0, 16'h0100, 16'h0000, 0, 16'h0000);
    check("lw.pc_load", pc, 16'h0100);
    step(0, 1, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0000);
    check("lw.req_start", 16'(mem_bus.mem_req), 16'h1);
    for (int unsigned c = 0; c < 5; c++) begin
      step(0, c[0] ? 1'b0 : 1'b1, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0000);
      check($sformatf("lw.c%0d.req", c),   16'(mem_bus.mem_req), 16'h1);
      check($sformatf("lw.c%0d.addr", c),  mem_bus.mem_addr,     16'h0100);
      check($sformatf("lw.c%0d.stall", c), 16'(stall),           16'h1);
      check($sformatf("lw.c%0d.done", c),  16'(fetch_done),      16'h0);
      check($sformatf("lw.c%0d.op", c),    16'(op),              16'hF);
    end
    seen_done = 1'b0;
    for (int unsigned c = 0; c < 4 && !seen_done; c++) begin
      step(0, 0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 1, 16'h7ABC);
      seen_done = fetch_done;
    end
    check("lw.done_seen", 16'(seen_done), 16'h1);
    check("lw.instr", instr, 16'h7ABC);
    check("lw.op", 16'(op), 16'h7);
    check("lw.stall_after", 16'(stall), 16'h0);
    check("lw.req_after", 16'(mem_bus.mem_req), 16'h0);
    step(0, 0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 1, 16'h7ABC);
    check("lw.done_one_cycle", 16'(fetch_done), 16'h0);

    // Reset asserted while a fetch is outstanding
    step(0, 1, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0000);
    check("rm.req", 16'(mem_bus.mem_req), 16'h1);
    step(0, 0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0000);
    step(0, 0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0000);
    step(1, 0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0000);
    check("rm.pc",    pc,                   16'h0000);
    check("rm.instr", instr,                16'h0000);
    check("rm.op",    16'(op),              16'h0);
    check("rm.req",   16'(mem_bus.mem_req), 16'h0);
    check("rm.addr",  mem_bus.mem_addr,     16'h0000);
    check("rm.stall", 16'(stall),           16'h0);
    for (int unsigned c = 0; c < 2; c++) begin
      step(0, 0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 1, 16'hBEEF);
      check($sformatf("rm.late%0d.instr", c), instr,                16'h0000);
      check($sformatf("rm.late%0d.done", c),  16'(fetch_done),      16'h0);
      check($sformatf("rm.late%0d.req", c),   16'(mem_bus.mem_req), 16'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "time limit reached");
  end

endmodule
